// File: rtl/fetch_mem_bridge_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch memory bridge: FSM state encodings,
// halfword byte offsets on the external bus and the bit slices of the
// assembled instruction word (opcode in the upper half, k16 in the lower).
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FB_IDLE  = 2'b00,
        FB_RD_HI = 2'b01,
        FB_RD_LO = 2'b10
    } fb_state_e;

    // Byte offset of each halfword within a 32-bit word.
    localparam logic [1:0] HW_HI = 2'b00;
    localparam logic [1:0] HW_LO = 2'b10;

    // Slices of the assembled word: OPC_HI = [31:16], K16_LO = [15:0].
    localparam int OPC_HI_MSB = 31;
    localparam int OPC_HI_LSB = 16;
    localparam int K16_LO_MSB = 15;
    localparam int K16_LO_LSB = 0;

endpackage

// File: rtl/fetch_mem_bridge_if.sv
// ----------------------------------------------------------------------------
// fetch_mem_bridge_if
// External 16-bit read bus between the fetch bridge and memory.
//   bus_rd    : read strobe, level, held until bus_ack
//   bus_addr  : halfword byte address
//   bus_ack   : read data valid this cycle
//   bus_rdata : read data
// Modports: master (bridge side), slave (memory side).
// ----------------------------------------------------------------------------
interface fetch_mem_bridge_if #(
    parameter int ADDR_W = 16
);
    logic              bus_rd;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ack;
    logic [15:0]       bus_rdata;

    modport master (
        output bus_rd,
        output bus_addr,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_rd,
        input  bus_addr,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/fetch_mem_bridge_line_buf.sv
// ----------------------------------------------------------------------------
// fetch_line_buf
// One-line instruction buffer: tag, 32-bit data and valid flag, with the hit
// comparator and the halfword fill/invalidate controls.
// Ports:
//   clk, a_rst     : clock, asynchronous active-low reset
//   i_req, i_tag   : current fetch request and its word tag
//   i_idle         : controller is idle (hits only allowed then)
//   i_wr_hi        : write opcode half from i_wdata
//   i_wr_lo        : write k16 half, tag and valid (completes the fill)
//   i_wdata        : halfword from the bus
//   i_fill_tag     : tag of the line being filled
//   i_fill_vld     : valid value committed with the final halfword
//   i_inval        : clear valid
//   o_hit, o_data  : hit indication and registered line data
// ----------------------------------------------------------------------------
module fetch_line_buf
    import fetch_pkg::*;
#(
    parameter int TAG_W = 14
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             i_req,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_idle,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [15:0]      i_wdata,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic             i_fill_vld,
    input  logic             i_inval,
    output logic             o_hit,
    output logic [31:0]      o_data
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (i_wr_hi) begin
                r_data[OPC_HI_MSB:OPC_HI_LSB] <= i_wdata;
            end
            // The final halfword commits tag and valid together; an aborted
            // fill still writes data but leaves the line invalid.
            if (i_wr_lo) begin
                r_data[K16_LO_MSB:K16_LO_LSB] <= i_wdata;
                r_tag                         <= i_fill_tag;
                r_valid                       <= i_fill_vld;
            end else if (i_inval) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_hit  = i_req & r_valid & (r_tag == i_tag) & i_idle;
    assign o_data = r_data;

endmodule

// File: rtl/fetch_mem_bridge.sv
// ----------------------------------------------------------------------------
// fetch_mem_bridge
// Serves 32-bit instruction-word fetches from a one-line buffer. A miss
// performs two 16-bit external reads (opcode half, then k16 half) and holds
// the core until the word is buffered. Flush invalidates the line, or marks
// an in-flight fill as aborted so its result is not kept valid.
// Ports:
//   clk, a_rst  : clock, asynchronous active-low reset
//   fetch_req   : fetch request this cycle
//   fetch_addr  : byte address, bits [1:0] ignored
//   flush       : invalidate the line buffer
//   fetch_opc   : buffered word {opcode, k16}
//   hold        : stall for fetch/decode
//   miss_cnt    : saturating miss counter
//   bus         : external read bus (master side)
// ----------------------------------------------------------------------------
module fetch_mem_bridge
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              flush,
    output logic [31:0]       fetch_opc,
    output logic              hold,
    output logic [CNT_W-1:0]  miss_cnt,
    fetch_mem_bridge_if.master bus
);

    localparam int TAG_W = ADDR_W - 2;

    fb_state_e        r_state;
    fb_state_e        w_state_nxt;
    logic [TAG_W-1:0] r_pend_tag;
    logic             r_abort;
    logic [CNT_W-1:0] r_miss_cnt;

    logic             w_hit;
    logic             w_miss;
    logic             w_wr_hi;
    logic             w_wr_lo;
    logic             w_idle;
    logic             w_unused_addr_lsb;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_idle            = (r_state == FB_IDLE);
    assign w_unused_addr_lsb = ^fetch_addr[1:0];

    fetch_line_buf #(
        .TAG_W (TAG_W)
    ) u_line_buf (
        .clk        (clk),
        .a_rst      (a_rst),
        .i_req      (fetch_req),
        .i_tag      (fetch_addr[ADDR_W-1:2]),
        .i_idle     (w_idle),
        .i_wr_hi    (w_wr_hi),
        .i_wr_lo    (w_wr_lo),
        .i_wdata    (bus.bus_rdata),
        .i_fill_tag (r_pend_tag),
        .i_fill_vld (~(r_abort | flush)),
        .i_inval    (flush & w_idle),
        .o_hit      (w_hit),
        .o_data     (fetch_opc)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_miss       = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        bus.bus_rd   = 1'b0;
        bus.bus_addr = '0;
        case (r_state)
            FB_IDLE: begin
                if (fetch_req && !w_hit) begin
                    w_miss      = 1'b1;
                    w_state_nxt = FB_RD_HI;
                end
            end
            FB_RD_HI: begin
                bus.bus_rd   = 1'b1;
                bus.bus_addr = {r_pend_tag, HW_HI};
                if (bus.bus_ack) begin
                    w_wr_hi     = 1'b1;
                    w_state_nxt = FB_RD_LO;
                end
            end
            FB_RD_LO: begin
                bus.bus_rd   = 1'b1;
                bus.bus_addr = {r_pend_tag, HW_LO};
                if (bus.bus_ack) begin
                    w_wr_lo     = 1'b1;
                    w_state_nxt = FB_IDLE;
                end
            end
            default: w_state_nxt = FB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_state    <= FB_IDLE;
            r_pend_tag <= '0;
            r_abort    <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) begin
                r_pend_tag <= fetch_addr[ADDR_W-1:2];
                r_abort    <= 1'b0;
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end else if (flush && !w_idle) begin
                // Fill keeps running to bus_ack; only its valid commit is dropped.
                r_abort <= 1'b1;
            end
        end
    end

    assign hold     = fetch_req & ~w_hit;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_fetch_mem_bridge.sv
module tb_fetch_mem_bridge;
    import fetch_pkg::*;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              a_rst = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              flush = 1'b0;
    logic [31:0]       fetch_opc;
    logic              hold;
    logic [CNT_W-1:0]  miss_cnt;

    fetch_mem_bridge_if #(.ADDR_W(ADDR_W)) bif ();

    fetch_mem_bridge #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .a_rst      (a_rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .flush      (flush),
        .fetch_opc  (fetch_opc),
        .hold       (hold),
        .miss_cnt   (miss_cnt),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int bus_wait = 0;
    logic [31:0]       exp_fetch_q[$];
    logic [ADDR_W-1:0] exp_bus_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // Directed memory image; unlisted halfwords read as addr ^ 0xF00F.
    function automatic logic [15:0] mem_hw(input logic [15:0] a);
        case (a)
            16'h0000: return 16'hA912;
            16'h0002: return 16'h3456;
            16'h0104: return 16'hBEEF;
            16'h0106: return 16'hCAFE;
            16'h0200: return 16'h1357;
            16'h0202: return 16'h2468;
            default:  return a ^ 16'hF00F;
        endcase
    endfunction

    // Memory responder: acks each read after bus_wait idle cycles.
    int rsp_cnt = 0;
    initial begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bif.bus_rd) begin
                if (rsp_cnt == bus_wait) begin
                    bif.bus_ack   = 1'b1;
                    bif.bus_rdata = mem_hw(bif.bus_addr);
                    rsp_cnt       = 0;
                end else begin
                    bif.bus_ack = 1'b0;
                    rsp_cnt++;
                end
            end else begin
                bif.bus_ack = 1'b0;
                rsp_cnt     = 0;
            end
        end
    end

    // Scoreboard monitor: served fetches and every active bus cycle.
    always @(negedge clk) begin
        if (a_rst) begin
            if (fetch_req && !hold) begin
                if (exp_fetch_q.size() == 0) fail_now("unexpected fetch served");
                else chk("fetch_opc", fetch_opc, exp_fetch_q.pop_front());
            end
            if (bif.bus_rd) begin
                if (exp_bus_q.size() == 0) begin
                    fail_now($sformatf("unexpected bus_rd addr 0x%0h", bif.bus_addr));
                end else begin
                    chk("bus_addr", bif.bus_addr, exp_bus_q[0]);
                    if (bif.bus_ack) void'(exp_bus_q.pop_front());
                end
            end
        end
    end

    task automatic do_fetch(input logic [15:0] a, input logic [31:0] w,
                            input int exp_hold, input int fills, input string nm);
        int  h;
        bit  done;
        for (int f = 0; f < fills; f++) begin
            exp_bus_q.push_back({a[15:2], HW_HI});
            exp_bus_q.push_back({a[15:2], HW_LO});
        end
        exp_fetch_q.push_back(w);
        fetch_req  = 1'b1;
        fetch_addr = a;
        h = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (hold) h++;
            else done = 1'b1;
        end
        if (!done) fail_now({nm, " timeout waiting for hold low"});
        chk({nm, " hold cycles"}, h, exp_hold);
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        // Reset state
        #2;
        chk("rst fetch_opc", fetch_opc, 32'h0);
        chk("rst bus_rd", bif.bus_rd, 1'b0);
        chk("rst bus_addr", bif.bus_addr, 16'h0);
        chk("rst miss_cnt", miss_cnt, 4'h0);
        chk("rst hold req0", hold, 1'b0);
        fetch_req = 1'b1;
        #1;
        chk("rst hold req1", hold, 1'b1);
        fetch_req = 1'b0;
        @(posedge clk);
        #1;
        a_rst = 1'b1;

        // Zero-wait miss then hits (addr bits [1:0] ignored)
        bus_wait = 0;
        do_fetch(16'h0000, 32'hA9123456, 3, 1, "miss0");
        chk("cnt after miss0", miss_cnt, 4'd1);
        do_fetch(16'h0000, 32'hA9123456, 0, 0, "hit0");
        do_fetch(16'h0003, 32'hA9123456, 0, 0, "hit3");
        chk("cnt after hits", miss_cnt, 4'd1);

        // Two wait cycles per halfword
        bus_wait = 2;
        do_fetch(16'h0104, 32'hBEEFCAFE, 7, 1, "miss104");
        chk("cnt after miss104", miss_cnt, 4'd2);

        // Flush during RD_HI: fill completes invalid, request refills
        bus_wait = 0;
        fork
            do_fetch(16'h0200, 32'h13572468, 6, 2, "flush200");
            begin
                @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        chk("cnt after flush", miss_cnt, 4'd4);
        do_fetch(16'h0200, 32'h13572468, 0, 0, "hit200");

        // Async reset during RD_LO
        bus_wait = 2;
        exp_bus_q.push_back(16'h0300);
        exp_bus_q.push_back(16'h0302);
        fetch_req  = 1'b1;
        fetch_addr = 16'h0300;
        repeat (4) @(posedge clk);
        #2;
        chk("pre-rst bus_addr RD_LO", bif.bus_addr, 16'h0302);
        #1 a_rst = 1'b0;
        #1;
        chk("midrst bus_rd", bif.bus_rd, 1'b0);
        chk("midrst fetch_opc", fetch_opc, 32'h0);
        chk("midrst miss_cnt", miss_cnt, 4'h0);
        chk("midrst hold", hold, 1'b1);
        fetch_req = 1'b0;
        #1;
        chk("midrst hold req0", hold, 1'b0);
        exp_bus_q.delete();
        @(posedge clk);
        #1 a_rst = 1'b1;
        bus_wait = 0;
        do_fetch(16'h0000, 32'hA9123456, 3, 1, "refill0");
        chk("cnt after refill", miss_cnt, 4'd1);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            a = 16'h1000 + 16'(4 * i);
            do_fetch(a, {a ^ 16'hF00F, (a | 16'h0002) ^ 16'hF00F}, 3, 1,
                     $sformatf("sweep%0d", i));
            chk($sformatf("sat cnt %0d", i), miss_cnt, (i + 2 > 15) ? 4'hF : 4'(i + 2));
        end
        do_fetch(16'h103C, {16'h103C ^ 16'hF00F, 16'h103E ^ 16'hF00F}, 0, 0, "hit last");
        chk("cnt held at max", miss_cnt, 4'hF);

        repeat (2) @(posedge clk);
        chk("fetch queue drained", exp_fetch_q.size(), 0);
        chk("bus queue drained", exp_bus_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
